// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: multiply request/response bundle between requester (master) and sequencer (slave)
interface alu_mul_sequencer_if;
    logic        Start;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [31:0] Product;
    modport master (output Start, OpA, OpB, input Ready, Busy, Done, Product);
    modport slave (input Start, OpA, OpB, output Ready, Busy, Done, Product);
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 32x32 multiplier (low word) sharing the single-cycle ALU, pass-through when idle
// ports: bus = Start/OpA/OpB in, Ready/Busy/Done/Product out; Ext_* = requester ALU request; Data1/Data2/ALU_Op/ALUResult = ALU link
module alu_mul_sequencer (
    input  logic                clk,
    input  logic                rst_n,
    alu_mul_sequencer_if.slave  bus,
    input  logic [31:0]         Ext_Data1,
    input  logic [31:0]         Ext_Data2,
    input  logic [3:0]          Ext_ALU_Op,
    output logic [31:0]         Data1,
    output logic [31:0]         Data2,
    output logic [3:0]          ALU_Op,
    input  logic [31:0]         ALUResult
);
    localparam logic [3:0] OP_SLL = 4'b0000;
    localparam logic [3:0] OP_SRL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b1100;
    localparam logic [3:0] OP_ADD = 4'b1000;
    typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, SHR, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic [31:0] product_q, product_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            product_q <= product_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        Data1    = Ext_Data1;
        Data2    = Ext_Data2;
        ALU_Op   = Ext_ALU_Op;
        case (state_q)
            IDLE: if (bus.Start) begin
                mcand_d  = bus.OpA;
                mplier_d = bus.OpB;
                prod_d   = '0;
                state_d  = bus.OpB == '0 ? DONE : TEST;
            end
            TEST: begin
                ALU_Op  = OP_AND;
                Data1   = mplier_q;
                Data2   = 32'd1;
                state_d = ALUResult[0] ? ADD : SHL;
            end
            ADD: begin
                ALU_Op  = OP_ADD;
                Data1   = prod_q;
                Data2   = mcand_q;
                prod_d  = ALUResult;
                state_d = SHL;
            end
            SHL: begin
                ALU_Op  = OP_SLL;
                Data1   = mcand_q;
                Data2   = 32'd1;
                mcand_d = ALUResult;
                state_d = SHR;
            end
            SHR: begin
                ALU_Op   = OP_SRL;
                Data1    = mplier_q;
                Data2    = 32'd1;
                mplier_d = ALUResult;
                state_d  = ALUResult == '0 ? DONE : TEST;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Product is captured on the edge that enters DONE so it is already valid while Done is high
        product_d = state_d == DONE ? prod_d : product_q;
    end
    assign bus.Ready   = state_q == IDLE;
    assign bus.Busy    = state_q inside {TEST, ADD, SHL, SHR};
    assign bus.Done    = state_q == DONE;
    assign bus.Product = product_q;
endmodule
